conv_seq_ctrl: RTL and testbench
================================

CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

Interface
REQ-001 The block SHALL have parameter CHAN, default 10: channels per frame that the conv datapath processes.
REQ-002 The block SHALL have parameter TMO_CYC, default 4096: watchdog limit in cycles for RUN.
REQ-003 The block SHALL have parameter FCNT_W, default 16: width of the frame counter.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 img_valid  input  1  host has a complete image and weights staged.
REQ-007 img_ready  output  1  controller accepts a frame.
REQ-008 conv_trigger  output  1  one-cycle start pulse to the conv datapath.
REQ-009 conv1_valid  input  1  per-channel completion pulse from stage 1.
REQ-010 conv1_chan  input  4  channel index accompanying conv1_valid.
REQ-011 conv_out_valid  input  1  final accumulated result valid.
REQ-012 res_valid  output  1  result held for the consumer.
REQ-013 res_ready  input  1  consumer accepts the result.
REQ-014 clr_err  input  1  clears ERR.
REQ-015 busy  output  1  high in TRIG, RUN and RESULT.
REQ-016 err  output  1  high in ERR.
REQ-017 chan_prog  output  4  count of conv1_valid pulses seen in the current frame.
REQ-018 frame_cnt  output  FCNT_W  count of completed frames; wraps modulo 2^FCNT_W.

Function
REQ-019 The FSM SHALL have the states IDLE, TRIG, RUN, RESULT and ERR.
REQ-020 IDLE SHALL drive img_ready=1 and go to TRIG when img_valid=1; img_ready SHALL be 0 in every other state.
REQ-021 TRIG SHALL last exactly one cycle with conv_trigger=1 and clear chan_prog; conv_trigger SHALL be 0 in every other state.
REQ-022 In RUN, each conv1_valid SHALL increment chan_prog, saturating at CHAN.
REQ-023 In RUN, a conv1_valid whose conv1_chan differs from the pre-increment chan_prog SHALL move the FSM to ERR on the next cycle.
REQ-024 In RUN, conv_out_valid SHALL move the FSM to RESULT if chan_prog, including any conv1_valid in the same cycle, equals CHAN; otherwise it SHALL move the FSM to ERR.
REQ-025 If conv1_valid with a mismatched channel and conv_out_valid occur in the same cycle, the FSM SHALL go to ERR.
REQ-026 RESULT SHALL drive res_valid=1 until res_ready=1, then increment frame_cnt and return to IDLE in the same edge; res_valid SHALL be 0 outside RESULT.
REQ-027 conv1_valid and conv_out_valid outside RUN SHALL be ignored, except in IDLE/TRIG where they SHALL move the FSM to ERR (spurious completion).
REQ-028 ERR SHALL hold until clr_err=1, then return to IDLE with chan_prog cleared; frame_cnt SHALL be unchanged.
REQ-029 Latency SHALL be: img_valid&&img_ready at edge N -> conv_trigger high in cycle N+1; res_ready in RESULT -> img_ready high on the next cycle.

Reset
REQ-030 On rst_n=0 the block SHALL immediately set the FSM to IDLE and clear chan_prog, frame_cnt and the watchdog; after reset img_ready=1 and all other outputs are 0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame with no res_valid.

Configuration
REQ-032 With CONV_SEQ_CTRL_WDOG_EN defined, a counter SHALL clear on entry to RUN and on each conv1_valid, increment each other RUN cycle, and move the FSM to ERR when it reaches TMO_CYC.
REQ-033 Without CONV_SEQ_CTRL_WDOG_EN, RUN SHALL have no timeout and the counter SHALL be absent.

Structure
REQ-034 The state enum, the default CHAN value and the 4-bit channel-index width SHALL be placed in the shared package npu_pkg.
REQ-035 The watchdog SHALL be a sub-module conv_wdog (count, clear, limit -> expire), instantiated only under the macro.

Verification
REQ-036 Nominal: img_valid=1; CHAN=10 conv1_valid pulses with chan 0..9; then conv_out_valid; res_ready=1 -> one conv_trigger pulse, chan_prog=10, res_valid for 1 cycle, frame_cnt=1.
REQ-037 Back-pressure: res_ready held 0 for 20 cycles -> res_valid stays 1 and img_ready stays 0 throughout; frame_cnt increments only on the accepting edge.
REQ-038 Channel mismatch: third conv1_valid carries chan=5 -> err=1 next cycle; clr_err -> IDLE with chan_prog=0.
REQ-039 Early final: conv_out_valid after 7 channels -> ERR; a spurious conv_out_valid in IDLE -> ERR.
REQ-040 Watchdog (macro on, TMO_CYC=64): no conv1_valid after trigger -> err at RUN cycle 64; macro off -> remains in RUN.
REQ-041 Reset mid-RUN at channel 4 -> all outputs at reset values; the next frame completes normally with frame_cnt=1.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared NPU definitions: controller state encoding, channel-index width
// and the default channel count per frame.
package npu_pkg;

    localparam int CHAN_DEF = 10;
    localparam int CHAN_W   = 4;

    typedef logic [CHAN_W-1:0] chan_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_TRIG   = 3'd1,
        ST_RUN    = 3'd2,
        ST_RESULT = 3'd3,
        ST_ERR    = 3'd4
    } state_e;

    function automatic chan_t sat_inc(chan_t v, chan_t lim);
        return (v >= lim) ? lim : v + chan_t'(1);
    endfunction

endpackage

// File: rtl/conv_seq_ctrl_if.sv
// Host, conv-datapath and consumer handshake bundle of conv_seq_ctrl.
// master = environment side, slave = controller side.
interface conv_seq_ctrl_if;
    import npu_pkg::*;

    logic  img_valid;
    logic  img_ready;
    logic  conv_trigger;
    logic  conv1_valid;
    chan_t conv1_chan;
    logic  conv_out_valid;
    logic  res_valid;
    logic  res_ready;

    modport master (
        output img_valid, conv1_valid, conv1_chan,
        output conv_out_valid, res_ready,
        input  img_ready, conv_trigger, res_valid
    );

    modport slave (
        input  img_valid, conv1_valid, conv1_chan,
        input  conv_out_valid, res_ready,
        output img_ready, conv_trigger, res_valid
    );

endinterface

// File: rtl/conv_wdog.sv
// RUN-phase watchdog: counts while count_i, restarts on clr_i and flags
// expire_o on the cycle whose edge would bring the count to LIMIT.
module conv_wdog #(
    parameter int LIMIT = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic count_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)        cnt_d = '0;
        else if (count_i) cnt_d = cnt_q + W'(1);
    end

    assign expire_o = count_i && !clr_i && (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/conv_seq_ctrl.sv
// Convolution frame sequencer: trigger, per-channel tracking, result hold.
// Define CONV_SEQ_CTRL_WDOG_EN to add the RUN-phase watchdog (conv_wdog).
module conv_seq_ctrl
    import npu_pkg::*;
#(
    parameter int CHAN    = CHAN_DEF,
    parameter int TMO_CYC = 4096,
    parameter int FCNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    conv_seq_ctrl_if.slave    bus,
    input  logic              clr_err,
    output logic              busy,
    output logic              err,
    output chan_t             chan_prog,
    output logic [FCNT_W-1:0] frame_cnt
);

    state_e            state_q, state_d;
    chan_t             chan_q, chan_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;

    logic  c1, co;
    logic  mis;
    logic  wdog_exp;
    chan_t chan_inc, chan_after;

    assign c1 = bus.conv1_valid;
    assign co = bus.conv_out_valid;

    always_comb begin
        chan_inc   = sat_inc(chan_q, chan_t'(CHAN));
        chan_after = c1 ? chan_inc : chan_q;
        mis        = c1 && (bus.conv1_chan != chan_q);
    end

`ifdef CONV_SEQ_CTRL_WDOG_EN
    conv_wdog #(
        .LIMIT (TMO_CYC)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .count_i  (state_q == ST_RUN),
        .clr_i    ((state_q != ST_RUN) || c1),
        .expire_o (wdog_exp)
    );
`else
    // No timeout: RUN waits for the datapath indefinitely.
    assign wdog_exp = 1'b0 && (TMO_CYC > 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (c1 || co)         state_d = ST_ERR;
                else if (bus.img_valid) state_d = ST_TRIG;
            end
            ST_TRIG: begin
                if (c1 || co) state_d = ST_ERR;
                else          state_d = ST_RUN;
            end
            ST_RUN: begin
                // A channel mismatch wins over a simultaneous final result.
                if (mis)           state_d = ST_ERR;
                else if (co)       state_d = (chan_after == chan_t'(CHAN))
                                           ? ST_RESULT : ST_ERR;
                else if (wdog_exp) state_d = ST_ERR;
            end
            ST_RESULT: begin
                if (bus.res_ready) state_d = ST_IDLE;
            end
            ST_ERR: begin
                if (clr_err) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chan_q <= '0;
            fcnt_q <= '0;
        end else begin
            chan_q <= chan_d;
            fcnt_q <= fcnt_d;
        end
    end

    always_comb begin
        chan_d = chan_q;
        fcnt_d = fcnt_q;
        unique case (1'b1)
            state_q == ST_TRIG:                 chan_d = '0;
            state_q == ST_RUN && c1:            chan_d = chan_inc;
            state_q == ST_RESULT && bus.res_ready:
                fcnt_d = fcnt_q + FCNT_W'(1);
            state_q == ST_ERR && clr_err:       chan_d = '0;
            default: ;
        endcase
    end

    always_comb begin
        bus.img_ready    = (state_q == ST_IDLE);
        bus.conv_trigger = (state_q == ST_TRIG);
        bus.res_valid    = (state_q == ST_RESULT);
        busy             = (state_q == ST_TRIG) || (state_q == ST_RUN)
                        || (state_q == ST_RESULT);
        err              = (state_q == ST_ERR);
        chan_prog        = chan_q;
        frame_cnt        = fcnt_q;
    end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Randomized frame-level bench for conv_seq_ctrl with a transaction model.
// Expected outcome of each frame is computed from its pulse list.
module tb_conv_seq_ctrl;
    import npu_pkg::*;

    localparam int CHAN = 10;
    localparam int TMO  = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr_err = 1'b0;
    logic        busy, err;
    chan_t       chan_prog;
    logic [15:0] frame_cnt;

    int checks = 0;
    int failures = 0;
    int exp_frames = 0;

    conv_seq_ctrl_if bus ();

    conv_seq_ctrl #(
        .CHAN    (CHAN),
        .TMO_CYC (TMO),
        .FCNT_W  (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .clr_err   (clr_err),
        .busy      (busy),
        .err       (err),
        .chan_prog (chan_prog),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.img_valid      = 1'b0;
        bus.conv1_valid    = 1'b0;
        bus.conv1_chan     = '0;
        bus.conv_out_valid = 1'b0;
        bus.res_ready      = 1'b0;
        clr_err            = 1'b0;
    endtask

    task automatic chk_idle(string t);
        chk({t, ".img_ready"}, 32'(bus.img_ready), 1);
        chk({t, ".busy"}, 32'(busy), 0);
        chk({t, ".err"}, 32'(err), 0);
        chk({t, ".res_valid"}, 32'(bus.res_valid), 0);
        chk({t, ".trig"}, 32'(bus.conv_trigger), 0);
        chk({t, ".fcnt"}, 32'(frame_cnt), 32'(exp_frames));
    endtask

    task automatic start_frame();
        chk_idle("pre");
        bus.img_valid = 1'b1;
        step();
        bus.img_valid = 1'b0;
        chk("trig.pulse", 32'(bus.conv_trigger), 1);
        chk("trig.img_ready", 32'(bus.img_ready), 0);
        chk("trig.busy", 32'(busy), 1);
        step();
        chk("run.trig_low", 32'(bus.conv_trigger), 0);
        chk("run.prog0", 32'(chan_prog), 0);
    endtask

    task automatic finish_err();
        int n;
        chk("err.flag", 32'(err), 1);
        chk("err.busy", 32'(busy), 0);
        chk("err.res_valid", 32'(bus.res_valid), 0);
        n = $urandom_range(0, 3);
        repeat (n) begin
            step();
            chk("err.hold", 32'(err), 1);
        end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("clr.err", 32'(err), 0);
        chk("clr.img_ready", 32'(bus.img_ready), 1);
        chk("clr.prog", 32'(chan_prog), 0);
        chk("clr.fcnt", 32'(frame_cnt), 32'(exp_frames));
    endtask

    task automatic finish_result(int hold);
        repeat (hold) begin
            chk("bp.res_valid", 32'(bus.res_valid), 1);
            chk("bp.img_ready", 32'(bus.img_ready), 0);
            chk("bp.fcnt", 32'(frame_cnt), 32'(exp_frames));
            step();
        end
        chk("res.valid", 32'(bus.res_valid), 1);
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        exp_frames = (exp_frames + 1) % 65536;
        chk("res.drop", 32'(bus.res_valid), 0);
        chk("res.img_ready", 32'(bus.img_ready), 1);
        chk("res.fcnt", 32'(frame_cnt), 32'(exp_frames));
    endtask

    // Model: pulse i must carry min(i, CHAN); the frame succeeds iff no
    // pulse is wrong and at least CHAN pulses precede/accompany the final.
    task automatic run_body(int np, int bad, int bad_ch, bit same, int hold);
        bit sent_out = 1'b0;
        for (int i = 0; i < np; i++) begin
            int exp_ch = (i < CHAN) ? i : CHAN;
            repeat ($urandom_range(0, 2)) step();
            bus.conv1_valid = 1'b1;
            bus.conv1_chan  = (i == bad) ? chan_t'(bad_ch) : chan_t'(exp_ch);
            if (same && i == np - 1) begin
                bus.conv_out_valid = 1'b1;
                sent_out = 1'b1;
            end
            step();
            bus.conv1_valid    = 1'b0;
            bus.conv_out_valid = 1'b0;
            if (i == bad) begin
                finish_err();
                return;
            end
            if (!sent_out)
                chk("run.prog", 32'(chan_prog), 32'((i + 1 < CHAN) ? i + 1 : CHAN));
        end
        if (!sent_out) begin
            repeat ($urandom_range(0, 2)) step();
            bus.conv_out_valid = 1'b1;
            step();
            bus.conv_out_valid = 1'b0;
        end
        if (np >= CHAN) begin
            chk("done.prog", 32'(chan_prog), CHAN);
            chk("done.err", 32'(err), 0);
            finish_result(hold);
        end else begin
            finish_err();
        end
    endtask

    task automatic run_frame(int np, int bad, int bad_ch, bit same, int hold);
        start_frame();
        run_body(np, bad, bad_ch, same, hold);
    endtask

    task automatic spurious(bit in_trig, bit use_out);
        chk_idle("sp");
        if (in_trig) begin
            bus.img_valid = 1'b1;
            step();
            bus.img_valid = 1'b0;
        end
        if (use_out) bus.conv_out_valid = 1'b1;
        else         bus.conv1_valid = 1'b1;
        step();
        quiet();
        finish_err();
    endtask

    task automatic chk_reset_outs();
        chk("rst.img_ready", 32'(bus.img_ready), 1);
        chk("rst.trig", 32'(bus.conv_trigger), 0);
        chk("rst.res_valid", 32'(bus.res_valid), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.err", 32'(err), 0);
        chk("rst.prog", 32'(chan_prog), 0);
        chk("rst.fcnt", 32'(frame_cnt), 0);
    endtask

    initial begin
        quiet();
        #12;
        chk_reset_outs();
        step();
        rst_n = 1'b1;
        step();

        run_frame(CHAN, -1, 0, 1'b0, 0);
        run_frame(CHAN, -1, 0, 1'b0, 20);
        run_frame(CHAN, 2, 5, 1'b0, 0);
        run_frame(7, -1, 0, 1'b0, 0);
        spurious(1'b0, 1'b1);
        run_frame(CHAN, CHAN - 1, 3, 1'b1, 0);
        run_frame(CHAN + 2, -1, 0, 1'b1, 1);

        start_frame();
`ifdef CONV_SEQ_CTRL_WDOG_EN
        repeat (TMO - 1) step();
        chk("wdog.before", 32'(err), 0);
        step();
        chk("wdog.fire", 32'(err), 1);
        finish_err();
`else
        repeat (100) step();
        chk("nowdog.busy", 32'(busy), 1);
        chk("nowdog.err", 32'(err), 0);
        run_body(CHAN, -1, 0, 1'b0, 0);
`endif

        start_frame();
        for (int i = 0; i < 4; i++) begin
            bus.conv1_valid = 1'b1;
            bus.conv1_chan  = chan_t'(i);
            step();
            bus.conv1_valid = 1'b0;
        end
        chk("mid.prog4", 32'(chan_prog), 4);
        #2 rst_n = 1'b0;
        #1;
        exp_frames = 0;
        chk_reset_outs();
        step();
        rst_n = 1'b1;
        step();
        run_frame(CHAN, -1, 0, 1'b0, 0);
        chk("post_rst.fcnt1", 32'(frame_cnt), 1);

        for (int k = 0; k < 40; k++) begin
            int kind = $urandom_range(0, 4);
            case (kind)
                0, 1: run_frame(CHAN + $urandom_range(0, 2), -1, 0,
                                1'($urandom_range(0, 1)), $urandom_range(0, 5));
                2: begin
                    int idx = $urandom_range(0, CHAN - 1);
                    int wr  = (idx + 1 + $urandom_range(0, 13)) % 16;
                    run_frame(CHAN, idx, wr, 1'($urandom_range(0, 1)), 0);
                end
                3: run_frame($urandom_range(0, CHAN - 1), -1, 0,
                             1'($urandom_range(0, 1)), 0);
                default: spurious(1'($urandom_range(0, 1)),
                                  1'($urandom_range(0, 1)));
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
